// File: rtl/histogram_accumulator.sv
// Read-modify-write front end for a single-port histogram count RAM: clears the
// RAM after reset, increments bins per pixel, and dumps-and-clears on frame end.
module histogram_accumulator #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  ClockEn,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic [ADDR_WIDTH-1:0] pix_bin,
    input  logic                  frame_end,
    output logic                  hist_valid,
    input  logic                  hist_ready,
    output logic [DATA_WIDTH-1:0] hist_data,
    output logic                  hist_last,
    output logic                  busy,
    output logic                  ram_ClockEn,
    output logic                  ram_WE,
    output logic [ADDR_WIDTH-1:0] ram_Address,
    output logic [DATA_WIDTH-1:0] ram_Data,
    input  logic [DATA_WIDTH-1:0] ram_Q
);

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        INCR,
        DUMP_RD,
        DUMP_LAT,
        DUMP_OUT
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [DATA_WIDTH-1:0] MAX_COUNT = '1;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   bin_q, bin_d;
    logic                    pending_q, pending_d;
    logic [DATA_WIDTH-1:0]   hist_data_q, hist_data_d;
    logic                    we_c;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of block ordering.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q     <= CLEAR;
            addr_q      <= '0;
            bin_q       <= '0;
            pending_q   <= 1'b0;
            hist_data_q <= '0;
        end else if (ClockEn) begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            bin_q       <= bin_d;
            pending_q   <= pending_d;
            hist_data_q <= hist_data_d;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        bin_d       = bin_q;
        hist_data_d = hist_data_q;
        pending_d   = pending_q | frame_end;
        we_c        = 1'b0;
        ram_Address = addr_q;
        ram_Data    = '0;
        pix_ready   = 1'b0;
        hist_valid  = 1'b0;
        hist_last   = 1'b0;

        unique case (state_q)
            CLEAR: begin
                we_c = 1'b1;
                if (addr_q == LAST_ADDR) begin
                    state_d = IDLE;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            IDLE: begin
                // Read is issued on the accepting edge; data returns in INCR.
                pix_ready   = !pending_q;
                ram_Address = pix_bin;
                if (pending_q) begin
                    state_d   = DUMP_RD;
                    addr_d    = '0;
                    pending_d = frame_end;
                end else if (pix_valid) begin
                    bin_d   = pix_bin;
                    state_d = INCR;
                end
            end
            INCR: begin
                ram_Address = bin_q;
                we_c        = 1'b1;
                ram_Data    = (ram_Q == MAX_COUNT) ? ram_Q : ram_Q + DATA_WIDTH'(1);
                state_d     = IDLE;
            end
            DUMP_RD: begin
                state_d = DUMP_LAT;
            end
            DUMP_LAT: begin
                hist_data_d = ram_Q;
                we_c        = 1'b1;
                state_d     = DUMP_OUT;
            end
            DUMP_OUT: begin
                hist_valid = 1'b1;
                hist_last  = (addr_q == LAST_ADDR);
                if (hist_ready) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = IDLE;
                        addr_d  = '0;
                    end else begin
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        state_d = DUMP_RD;
                    end
                end
            end
            default: begin
                state_d = CLEAR;
                addr_d  = '0;
            end
        endcase
    end

    // Writes are suppressed while reset is held so the RAM is untouched until
    // the clear sweep starts on the first released edge.
    assign ram_WE      = we_c & Reset;
    assign ram_ClockEn = ClockEn;
    assign hist_data   = hist_data_q;
    assign busy        = pending_q || (state_q inside {CLEAR, DUMP_RD, DUMP_LAT, DUMP_OUT});

endmodule

// File: tb/tb_histogram_accumulator.sv
// Self-checking bench for histogram_accumulator: behavioural RAM models, a bin
// count array as reference, directed tables, random traffic and reset corners.
module tb_histogram_accumulator;

    localparam int AW     = 10;
    localparam int DW     = 32;
    localparam int NBINS  = 1 << AW;
    localparam int SAW    = 3;
    localparam int SDW    = 4;
    localparam int SNBINS = 1 << SAW;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic          Reset, ClockEn, pix_valid, pix_ready, frame_end;
    logic          hist_valid, hist_ready, hist_last, busy, ram_ClockEn, ram_WE;
    logic [AW-1:0] pix_bin, ram_Address;
    logic [DW-1:0] hist_data, ram_Data, ram_Q;
    logic [DW-1:0] mem [NBINS];

    logic           s_reset, s_cken, s_pix_valid, s_pix_ready, s_frame_end;
    logic           s_hist_valid, s_hist_ready, s_hist_last, s_busy, s_ram_ce, s_ram_we;
    logic [SAW-1:0] s_pix_bin, s_ram_addr;
    logic [SDW-1:0] s_hist_data, s_ram_data, s_ram_q;
    logic [SDW-1:0] smem [SNBINS];

    logic scramble;

    histogram_accumulator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .Clock(Clock), .Reset(Reset), .ClockEn(ClockEn),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_bin(pix_bin),
        .frame_end(frame_end),
        .hist_valid(hist_valid), .hist_ready(hist_ready), .hist_data(hist_data),
        .hist_last(hist_last), .busy(busy),
        .ram_ClockEn(ram_ClockEn), .ram_WE(ram_WE), .ram_Address(ram_Address),
        .ram_Data(ram_Data), .ram_Q(ram_Q)
    );

    histogram_accumulator #(.ADDR_WIDTH(SAW), .DATA_WIDTH(SDW)) dut_small (
        .Clock(Clock), .Reset(s_reset), .ClockEn(s_cken),
        .pix_valid(s_pix_valid), .pix_ready(s_pix_ready), .pix_bin(s_pix_bin),
        .frame_end(s_frame_end),
        .hist_valid(s_hist_valid), .hist_ready(s_hist_ready), .hist_data(s_hist_data),
        .hist_last(s_hist_last), .busy(s_busy),
        .ram_ClockEn(s_ram_ce), .ram_WE(s_ram_we), .ram_Address(s_ram_addr),
        .ram_Data(s_ram_data), .ram_Q(s_ram_q)
    );

    // Single-port RAMs with registered read; filled with garbage on the first
    // edge so that the clear sweep is actually exercised.
    always @(posedge Clock) begin
        if (scramble) begin
            for (int i = 0; i < NBINS; i++) mem[i] <= $urandom;
        end else if (ram_ClockEn) begin
            if (ram_WE) mem[ram_Address] <= ram_Data;
            ram_Q <= mem[ram_Address];
        end
    end

    always @(posedge Clock) begin
        if (scramble) begin
            for (int i = 0; i < SNBINS; i++) smem[i] <= SDW'($urandom);
        end else if (s_ram_ce) begin
            if (s_ram_we) smem[s_ram_addr] <= s_ram_data;
            s_ram_q <= smem[s_ram_addr];
        end
    end

    int          n_checks = 0;
    int          n_pass   = 0;
    int unsigned model [NBINS];
    logic [DW-1:0] got [NBINS];

    typedef struct {
        int bin;
        int reps;
        int exp_count;
    } vec_t;

    vec_t vecs [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expected);
        n_checks++;
        if (act === expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, expected);
    endtask

    task automatic next_cycle();
        @(negedge Clock);
    endtask

    task automatic model_incr(input int b);
        if (model[b] != 32'hFFFF_FFFF) model[b]++;
    endtask

    task automatic model_zero();
        for (int i = 0; i < NBINS; i++) model[i] = 0;
    endtask

    task automatic send_pixel(input int b);
        bit done = 1'b0;
        pix_valid = 1'b1;
        pix_bin   = AW'(b);
        for (int k = 0; k < 4000 && !done; k++) begin
            if (pix_ready && ClockEn) begin
                model_incr(b);
                done = 1'b1;
            end
            next_cycle();
        end
        pix_valid = 1'b0;
        check("pix_accept", done, 1);
    endtask

    task automatic pulse_frame_end();
        frame_end = 1'b1;
        next_cycle();
        frame_end = 1'b0;
    endtask

    task automatic wait_clear();
        int cyc = 1;
        while (!pix_ready && cyc < 3000) begin
            next_cycle();
            cyc++;
        end
        check("clear_cycles", cyc, 1025);
    endtask

    // Consumes dump words, comparing against the model; stop_idx >= 0 returns
    // with that bin on the output and hist_ready low.
    task automatic run_dump(input int stall_pct, input bit cken_pulses, input int stop_idx);
        int            idx     = 0;
        bit            held    = 1'b0;
        bit            stopped = 1'b0;
        logic [DW-1:0] held_data = '0;
        for (int k = 0; k < 40000 && idx < NBINS && !stopped; k++) begin
            if (held) begin
                check("stall_valid", hist_valid, 1);
                check("stall_data", hist_data, held_data);
            end
            if (hist_valid && idx == stop_idx) begin
                stopped    = 1'b1;
                hist_ready = 1'b0;
                ClockEn    = 1'b1;
            end else begin
                hist_ready = ($urandom_range(0, 99) >= stall_pct);
                ClockEn    = cken_pulses ? ($urandom_range(0, 7) != 0) : 1'b1;
                if (hist_valid && hist_ready && ClockEn) begin
                    got[idx] = hist_data;
                    check("dump_data", hist_data, model[idx]);
                    check("dump_last", hist_last, idx == NBINS - 1);
                    model[idx] = 0;
                    idx++;
                    held = 1'b0;
                end else begin
                    held      = hist_valid;
                    held_data = hist_data;
                end
                next_cycle();
            end
        end
        if (!stopped) begin
            ClockEn    = 1'b1;
            hist_ready = 1'b0;
            check("dump_words", idx, NBINS);
            next_cycle();
            check("idle_valid", hist_valid, 0);
            check("idle_busy", busy, 0);
        end
    endtask

    initial begin
        int n;
        int acc;
        int words;
        bit prev_acc;

        vecs[0] = '{bin: 5,    reps: 3, exp_count: 3};
        vecs[1] = '{bin: 1023, reps: 1, exp_count: 1};
        vecs[2] = '{bin: 0,    reps: 1, exp_count: 1};

        model_zero();
        scramble    = 1'b1;
        Reset       = 1'b0;
        ClockEn     = 1'b1;
        pix_valid   = 1'b0;
        pix_bin     = '0;
        frame_end   = 1'b0;
        hist_ready  = 1'b0;
        s_reset     = 1'b0;
        s_cken      = 1'b1;
        s_pix_valid = 1'b0;
        s_pix_bin   = '0;
        s_frame_end = 1'b0;
        s_hist_ready = 1'b0;

        next_cycle();
        scramble = 1'b0;
        next_cycle();

        check("rst_ram_we", ram_WE, 0);
        check("rst_pix_ready", pix_ready, 0);
        check("rst_hist_valid", hist_valid, 0);
        check("rst_hist_last", hist_last, 0);
        check("rst_hist_data", hist_data, 0);
        check("rst_busy", busy, 1);
        check("ram_clock_en", ram_ClockEn, 1);

        Reset   = 1'b1;
        s_reset = 1'b1;
        wait_clear();
        check("idle_busy_init", busy, 0);

        // Empty histogram dump and its start-up latency.
        pulse_frame_end();
        check("pending_busy", busy, 1);
        check("pending_ready", pix_ready, 0);
        n = 0;
        while (!hist_valid && n < 10) begin
            next_cycle();
            n++;
        end
        check("dump_latency", n, 3);
        run_dump(0, 1'b0, -1);

        // Directed table of pixel bursts; then a second dump must be empty.
        for (int v = 0; v < 3; v++)
            for (int r = 0; r < vecs[v].reps; r++) send_pixel(vecs[v].bin);
        pulse_frame_end();
        run_dump(0, 1'b0, -1);
        for (int v = 0; v < 3; v++) check("table_count", got[vecs[v].bin], vecs[v].exp_count);
        check("table_other", got[6], 0);
        pulse_frame_end();
        run_dump(0, 1'b0, -1);

        // pix_valid held for 100 cycles: one accept every other cycle.
        pix_valid = 1'b1;
        pix_bin   = AW'(7);
        acc = 0;
        for (int i = 0; i < 100; i++) begin
            if (pix_ready && ClockEn) begin
                acc++;
                model_incr(7);
            end
            next_cycle();
        end
        pix_valid = 1'b0;
        check("hold_accepts", acc, 50);
        next_cycle();
        pulse_frame_end();
        run_dump(0, 1'b0, -1);
        check("hold_bin7", got[7], 50);

        // Random pixel traffic with ClockEn gaps, then a stalled, gated dump.
        prev_acc = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (prev_acc) check("incr_ready_low", pix_ready, 0);
            pix_valid = 1'($urandom_range(0, 1));
            pix_bin   = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NBINS - 1))
                                                    : AW'($urandom_range(10, 13));
            ClockEn   = ($urandom_range(0, 5) != 0);
            prev_acc  = pix_valid && pix_ready && ClockEn;
            if (prev_acc) model_incr(int'(pix_bin));
            next_cycle();
        end
        pix_valid = 1'b0;
        ClockEn   = 1'b1;
        next_cycle();
        pulse_frame_end();
        run_dump(30, 1'b1, -1);

        // frame_end on the same edge as a pixel accept.
        send_pixel(900);
        next_cycle();
        check("same_cycle_ready", pix_ready, 1);
        pix_valid = 1'b1;
        pix_bin   = AW'(42);
        frame_end = 1'b1;
        model_incr(42);
        next_cycle();
        pix_valid = 1'b0;
        frame_end = 1'b0;
        run_dump(10, 1'b0, -1);
        check("same_cycle_bin42", got[42], 1);
        check("same_cycle_bin900", got[900], 1);

        // Reset during DUMP_OUT of bin 300 abandons the dump and reruns CLEAR.
        send_pixel(100);
        send_pixel(700);
        send_pixel(1000);
        pulse_frame_end();
        run_dump(0, 1'b0, 300);
        check("stop_valid", hist_valid, 1);
        Reset = 1'b0;
        next_cycle();
        check("mid_rst_valid", hist_valid, 0);
        check("mid_rst_busy", busy, 1);
        check("mid_rst_ready", pix_ready, 0);
        check("mid_rst_we", ram_WE, 0);
        Reset = 1'b1;
        model_zero();
        wait_clear();
        check("post_rst_busy", busy, 0);
        pulse_frame_end();
        run_dump(0, 1'b0, -1);

        // Narrow instance: 20 increments of one bin saturate a 4-bit count.
        s_pix_valid = 1'b1;
        s_pix_bin   = SAW'(2);
        acc = 0;
        for (int k = 0; k < 200 && acc < 20; k++) begin
            if (s_pix_ready) acc++;
            next_cycle();
        end
        s_pix_valid = 1'b0;
        check("sat_accepts", acc, 20);
        s_frame_end = 1'b1;
        next_cycle();
        s_frame_end  = 1'b0;
        s_hist_ready = 1'b1;
        words = 0;
        for (int k = 0; k < 200 && words < SNBINS; k++) begin
            if (s_hist_valid) begin
                check("sat_data", s_hist_data, (words == 2) ? 15 : 0);
                check("sat_last", s_hist_last, words == SNBINS - 1);
                words++;
            end
            next_cycle();
        end
        check("sat_words", words, SNBINS);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/histogram_accumulator.md
# histogram_accumulator

Read-modify-write front end for the histogram pipeline's single-port count memory (`ram_dq`, 1024 x 32, registered read, one access per cycle). It accepts a stream of pixel bin indices and increments the matching bin count. On a frame-end pulse it streams every bin out in address order and zeroes each bin as it is read. After reset it also clears the whole memory before accepting pixels.

## Interface
- ADDR_WIDTH, 10, bin index width; number of bins is 2^ADDR_WIDTH.
- DATA_WIDTH, 32, bin count width; must equal the RAM word width.

- Clock  in  1  single clock for the block and the RAM.
- Reset  in  1  synchronous, active-low reset.
- ClockEn  in  1  global enable; when low, all state and outputs hold and no handshake completes.
- pix_valid  in  1  pixel bin is valid.
- pix_ready  out  1  block can accept a pixel this cycle.
- pix_bin  in  ADDR_WIDTH  bin index to increment.
- frame_end  in  1  single-cycle pulse requesting a dump.
- hist_valid  out  1  hist_data is valid.
- hist_ready  in  1  downstream accepts hist_data.
- hist_data  out  DATA_WIDTH  bin count, in ascending bin order.
- hist_last  out  1  high with the final bin (index 2^ADDR_WIDTH-1).
- busy  out  1  high in CLEAR, DUMP_* or with a dump pending.
- ram_ClockEn  out  1  equal to ClockEn.
- ram_WE  out  1  RAM write enable.
- ram_Address  out  ADDR_WIDTH  RAM address.
- ram_Data  out  DATA_WIDTH  RAM write data.
- ram_Q  in  DATA_WIDTH  RAM read data; valid on the cycle after the read address is sampled.

## Operation
- States: CLEAR, IDLE, INCR, DUMP_RD, DUMP_LAT, DUMP_OUT.
- CLEAR:
  - Writes 0 to one address per cycle, from 0 up to 2^ADDR_WIDTH-1.
  - After the last address, goes to IDLE.
- IDLE:
  - pix_ready = 1 only when no dump is pending.
  - ram_Address = pix_bin (combinational) and ram_WE = 0, so the read is issued on the accepting edge.
  - When a pixel is accepted, the bin is registered and the state goes to INCR.
- INCR:
  - ram_Address = registered bin, ram_WE = 1, ram_Data = ram_Q + 1.
  - The count saturates at all-ones and never wraps.
  - Next state is IDLE.
- frame_end:
  - Sets a sticky pending flag in any state.
  - The flag is taken only from IDLE: with the flag set, IDLE goes to DUMP_RD with dump address 0 and clears the flag.
  - A pixel being incremented in INCR completes before the dump starts.
  - A frame_end arriving during a dump sets the flag again, so another dump follows once the current one finishes.
- DUMP_RD:
  - Drives the dump address with WE = 0.
  - Next state is DUMP_LAT.
- DUMP_LAT:
  - Captures ram_Q into hist_data.
  - Writes 0 to the same address (clear-on-read).
  - Next state is DUMP_OUT.
- DUMP_OUT:
  - hist_valid = 1; hist_last = 1 when the address is the final bin.
  - hist_data stays stable until hist_ready.
  - On handshake at the final address, go to IDLE; otherwise increment the address and go to DUMP_RD.
- Pixels are not accepted in CLEAR or DUMP_*, or while a dump is pending.

## Timing
- Reset:
  - While Reset = 0 at a clock edge, the next state is CLEAR with clear address 0.
  - Reset values: ram_WE = 0, pix_ready = 0, hist_valid = 0, hist_last = 0, hist_data = 0, busy = 1, pending flag = 0.
  - Reset overrides every state, including mid-dump; the partial dump is abandoned.
- CLEAR duration: writes occur on the 2^ADDR_WIDTH edges after reset release. pix_ready is first 1 in the cycle after the last clear write (cycle 1025 for ADDR_WIDTH = 10).
- Pixel throughput: one pixel per 2 cycles; pix_ready is low in INCR. The same bin back-to-back is correct without forwarding, because the write completes before the next read.
- Dump: at least 3 cycles per bin (DUMP_RD, DUMP_LAT, DUMP_OUT), plus any hist_ready stall. hist_valid rises 2 cycles after entering DUMP_RD.
- ClockEn = 0 freezes everything, including the RAM; pix_ready and hist_valid keep their values but no transfer occurs.

## Test plan
- Reset low 2 cycles, then release → pix_ready rises at cycle 1025. A frame_end then dumps 1024 zeros, with hist_last only on word 1024 and busy low after.
- Pixels 5, 5, 5, 1023, 0, then frame_end → bin0 = 1, bin5 = 3, bin1023 = 1, all others 0. A second dump is all zeros.
- pix_valid held high with bin 7 for 100 cycles → exactly 50 accepted; the dump shows bin7 = 50.
- DATA_WIDTH = 4, twenty pixels to bin 2 → the dump shows bin2 = 15 (saturated).
- Random hist_ready stalls and ClockEn low pulses during a dump → hist_data is stable while stalled, no word is lost or duplicated, and 1024 words are output.
- frame_end in the same cycle as a pixel accept → the increment lands in this dump. Reset low for 1 cycle during DUMP_OUT of bin 300 → hist_valid = 0 next cycle, CLEAR reruns, and a later dump is all zeros.
